cavlc_bitstream_shifter: RTL and testbench

Bitstream front end of the CAVLC decoder. Accepts 32-bit MSB-first bitstream words from the stream source and keeps them in a 64-bit left-aligned bit buffer. It presents a 16-bit look-ahead window to CoeffTokenDecode, LevelDecode and ZeroDecode. It consumes bits on the ShiftEn/NumShift request muxed by the control FSM, and reports BarrelShifterReady back to it.

---
 rtl/cavlc_bitstream_shifter.sv | 79 +++++++
 tb/tb_cavlc_bitstream_shifter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cavlc_bitstream_shifter.sv
// CAVLC bitstream front end: left-aligned 64-bit bit buffer with 16-bit look-ahead window.
// Window/Ready follow registers (1 cycle after load/shift); InReady drops when the post-shift fill leaves no room for a word.
module cavlc_bitstream_shifter #(
  parameter int IN_W      = 32,
  parameter int WIN_W     = 16,
  parameter int BUF_W     = 64,
  parameter int MAX_SHIFT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BarrelShiftEn,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [IN_W-1:0]   InData,
  output logic              InReady,
  input  logic              ShiftEn,
  input  logic [4:0]        NumShift,
  output logic [WIN_W-1:0]  Window,
  output logic              BarrelShifterReady,
  output logic [6:0]        BitCount,
  output logic              ShiftErr,
  output logic [15:0]       WordsIn
);

  localparam logic [6:0] LoadLimit = 7'(BUF_W - IN_W);
  localparam logic [6:0] WordBits  = 7'(IN_W);
  localparam logic [6:0] WinBits   = 7'(WIN_W);
  localparam logic [4:0] MaxShift  = 5'(MAX_SHIFT);

  logic [BUF_W-1:0] bitBuf;
  logic [6:0]       bitCount;
  logic             shiftErr;
  logic [15:0]      wordsIn;

  logic             shiftReq;
  logic             shiftLegal;
  logic             shiftOk;
  logic [4:0]       shiftAmt;
  logic [6:0]       rem;
  logic             loadOk;
  logic [BUF_W-1:0] shiftedBuf;
  logic [BUF_W-1:0] appendWord;

  always_comb begin
    shiftReq   = ShiftEn & BarrelShiftEn;
    shiftLegal = (NumShift <= MaxShift) && ({2'b00, NumShift} <= bitCount);
    shiftOk    = shiftReq & shiftLegal;
    shiftAmt   = shiftOk ? NumShift : 5'd0;
    rem        = bitCount - {2'b00, shiftAmt};
    InReady    = BarrelShiftEn & ~Flush & ~Reset & (rem <= LoadLimit);
    loadOk     = InValid & InReady;
    shiftedBuf = bitBuf << shiftAmt;
    // Placing the word at the top and shifting right by rem appends it just after the last valid bit.
    appendWord = {InData, {(BUF_W-IN_W){1'b0}}} >> rem;
  end

  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      bitBuf   <= '0;
      bitCount <= '0;
      shiftErr <= 1'b0;
      wordsIn  <= '0;
    end else if (BarrelShiftEn) begin
      bitBuf   <= loadOk ? (shiftedBuf | appendWord) : shiftedBuf;
      bitCount <= rem + (loadOk ? WordBits : 7'd0);
      if (shiftReq && !shiftLegal)
        shiftErr <= 1'b1;
      if (loadOk)
        wordsIn <= wordsIn + 16'd1;
    end
  end

  assign Window             = bitBuf[BUF_W-1 -: WIN_W];
  assign BarrelShifterReady = (bitCount >= WinBits);
  assign BitCount           = bitCount;
  assign ShiftErr           = shiftErr;
  assign WordsIn            = wordsIn;

endmodule

// File: tb/tb_cavlc_bitstream_shifter.sv
// Directed + random stream bench for cavlc_bitstream_shifter; expectations queued by stimulus, checked by a negedge monitor.
module tb_cavlc_bitstream_shifter;

  logic        Clk = 1'b0;
  logic        Reset, BarrelShiftEn, Flush, InValid, ShiftEn;
  logic [31:0] InData;
  logic [4:0]  NumShift;
  logic        InReady, BarrelShifterReady, ShiftErr;
  logic [15:0] Window, WordsIn;
  logic [6:0]  BitCount;

  cavlc_bitstream_shifter dut (
    .Clk(Clk), .Reset(Reset), .BarrelShiftEn(BarrelShiftEn), .Flush(Flush),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .ShiftEn(ShiftEn), .NumShift(NumShift), .Window(Window),
    .BarrelShifterReady(BarrelShifterReady), .BitCount(BitCount),
    .ShiftErr(ShiftErr), .WordsIn(WordsIn)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [6:0]  bc;
    logic [15:0] win;
    logic        rdy;
    logic        err;
    logic [15:0] words;
    logic        inRdy;
    bit          chkInRdy;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  bit    bitQ[$];
  bit    randPhase = 1'b0;
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic expect_state(input string nm, input logic [6:0] bc, input logic [15:0] win,
                              input logic rdy, input logic err, input logic [15:0] words,
                              input bit chkIr, input logic ir);
    exp_t e;
    e.bc = bc; e.win = win; e.rdy = rdy; e.err = err; e.words = words;
    e.inRdy = ir; e.chkInRdy = chkIr;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic bse, input logic fl, input logic iv, input logic [31:0] d,
                       input logic se, input logic [4:0] ns);
    BarrelShiftEn = bse; Flush = fl; InValid = iv; InData = d; ShiftEn = se; NumShift = ns;
  endtask

  // Monitor: retires queued expectations and, in the random phase, checks consumed bits.
  always @(negedge Clk) begin
    while (expQ.size() > 0) begin
      exp_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      chk({n, ".BitCount"}, int'(BitCount), int'(e.bc));
      chk({n, ".Window"}, int'(Window), int'(e.win));
      chk({n, ".Ready"}, int'(BarrelShifterReady), int'(e.rdy));
      chk({n, ".ShiftErr"}, int'(ShiftErr), int'(e.err));
      chk({n, ".WordsIn"}, int'(WordsIn), int'(e.words));
      if (e.chkInRdy)
        chk({n, ".InReady"}, int'(InReady), int'(e.inRdy));
    end
    if (randPhase && ShiftEn && BarrelShiftEn && !Reset && !Flush && NumShift != 5'd0) begin
      logic [15:0] expBits;
      logic [15:0] mask;
      expBits = '0;
      mask = ~(16'hFFFF >> NumShift);
      if (bitQ.size() < int'(NumShift)) begin
        checks++;
        failures++;
        $display("FAIL rand_underflow: queued %0d bits, shift %0d", bitQ.size(), NumShift);
      end else begin
        for (int i = 0; i < int'(NumShift); i++)
          expBits[15-i] = bitQ.pop_front();
        chk("rand_bits", int'(Window & mask), int'(expBits));
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    Reset = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 5'd0);
    tick(); tick();
    drive(1, 0, 1, 32'h1111_1111, 0, 5'd0);
    expect_state("reset", 7'd0, 16'h0, 0, 0, 16'd0, 1, 0);
    tick();
    Reset = 1'b0;

    // Load, then shift+load in the same cycle, then walk the window.
    drive(1, 0, 1, 32'hA5C3_0F12, 0, 5'd0);
    expect_state("empty", 7'd0, 16'h0, 0, 0, 16'd0, 1, 1); tick();
    drive(1, 0, 1, 32'hFFFF_0000, 1, 5'd4);
    expect_state("load1", 7'd32, 16'hA5C3, 1, 0, 16'd1, 1, 1); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd16);
    expect_state("shld", 7'd60, 16'h5C30, 1, 0, 16'd2, 0, 0); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd12);
    expect_state("sh16", 7'd44, 16'hF12F, 1, 0, 16'd2, 0, 0); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd8);
    expect_state("sh12", 7'd32, 16'hFFFF, 1, 0, 16'd2, 0, 0); tick();
    drive(1, 0, 1, 32'h1234_5678, 0, 5'd0);
    expect_state("sh8", 7'd24, 16'hFF00, 1, 0, 16'd2, 1, 1); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd16);
    expect_state("load3", 7'd56, 16'hFF00, 1, 0, 16'd3, 0, 0); tick();
    // Full-ish buffer: word refused alone, accepted once a same-cycle shift makes room.
    drive(1, 0, 1, 32'hDEAD_BEEF, 0, 5'd0);
    expect_state("bc40_noshift", 7'd40, 16'h0012, 1, 0, 16'd3, 1, 0); tick();
    drive(1, 0, 1, 32'hDEAD_BEEF, 1, 5'd8);
    expect_state("bc40_shift8", 7'd40, 16'h0012, 1, 0, 16'd3, 1, 1); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd17);
    expect_state("full", 7'd64, 16'h1234, 1, 0, 16'd4, 1, 0); tick();
    drive(1, 1, 1, 32'hCAFE_F00D, 1, 5'd4);
    expect_state("err17", 7'd64, 16'h1234, 1, 1, 16'd4, 1, 0); tick();
    drive(1, 0, 1, 32'hABCD_1234, 0, 5'd0);
    expect_state("flushed", 7'd0, 16'h0, 0, 0, 16'd0, 1, 1); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd16);
    expect_state("reload", 7'd32, 16'hABCD, 1, 0, 16'd1, 0, 0); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd4);
    expect_state("bc16", 7'd16, 16'h1234, 1, 0, 16'd1, 0, 0); tick();
    drive(1, 0, 0, 32'h0, 1, 5'd13);
    expect_state("bc12", 7'd12, 16'h2340, 0, 0, 16'd1, 0, 0); tick();
    drive(1, 1, 0, 32'h0, 0, 5'd0);
    expect_state("err13", 7'd12, 16'h2340, 0, 1, 16'd1, 0, 0); tick();
    drive(1, 0, 1, 32'h0F0F_0F0F, 0, 5'd0);
    expect_state("flushed2", 7'd0, 16'h0, 0, 0, 16'd0, 0, 0); tick();
    // Disabled: no load, no shift, no error.
    drive(0, 0, 1, 32'hFFFF_FFFF, 1, 5'd5);
    expect_state("bse_off", 7'd32, 16'h0F0F, 1, 0, 16'd1, 1, 0); tick();
    drive(1, 0, 0, 32'h0, 0, 5'd0);
    expect_state("bse_hold", 7'd32, 16'h0F0F, 1, 0, 16'd1, 0, 0); tick();

    // Random stream: reassembled consumed bits must match the source.
    drive(1, 1, 0, 32'h0, 0, 5'd0); tick();
    drive(1, 0, 0, 32'h0, 0, 5'd0);
    randPhase = 1'b1;
    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      InValid  = 1'b1;
      InData   = $urandom;
      ShiftEn  = BarrelShifterReady && ($urandom_range(3) != 0);
      NumShift = 5'($urandom_range(16));
      #1;
      if (InReady) begin
        for (int b = 31; b >= 0; b--)
          bitQ.push_back(InData[b]);
        sent++;
      end
      tick();
      cyc++;
    end
    InValid = 1'b0;
    while (BarrelShifterReady && cyc < 20000) begin
      ShiftEn  = 1'b1;
      NumShift = 5'($urandom_range(16));
      tick();
      cyc++;
    end
    ShiftEn = 1'b0;
    randPhase = 1'b0;
    if (cyc >= 20000) begin
      checks++;
      failures++;
      $display("FAIL rand_timeout: sent %0d words in %0d cycles", sent, cyc);
    end
    chk("rand_leftover", int'(BitCount), bitQ.size());
    chk("rand_words", int'(WordsIn), 1000);
    chk("rand_err", int'(ShiftErr), 0);

    // Reset mid-stream discards everything.
    drive(1, 0, 1, 32'h8765_4321, 0, 5'd0); tick();
    Reset = 1'b1;
    drive(1, 0, 1, 32'h1357_9BDF, 1, 5'd3); tick();
    expect_state("midreset", 7'd0, 16'h0, 0, 0, 16'd0, 1, 0);
    tick();
    Reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 5'd0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
